// File: rtl/rv_pkg.sv
// Shared pipeline constants and types for the register-read stage.
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 16;

    typedef enum logic [1:0] {
        OF_IDLE = 2'd0,
        OF_READ = 2'd1,
        OF_HOLD = 2'd2
    } opfetch_state_t;

    // True when a writeback targets a real (non-x0) source register.
    function automatic logic wb_hits(input logic wr,
                                     input logic [REG_AW-1:0] wb_rd,
                                     input logic [REG_AW-1:0] rs);
        return wr && (wb_rd == rs) && (rs != 5'd0);
    endfunction

endpackage

// File: rtl/opfetch_fwd.sv
// Per-operand forwarding mux: live writeback override with x0 forced to zero.
module opfetch_fwd
    import rv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [REG_AW-1:0] idx,
    input  logic [W-1:0]      src,
    input  logic              wb_wr,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [W-1:0]      wb_data,
    output logic [W-1:0]      operand
);

    // Select x0 zero, same-cycle writeback, or the stage's own source.
    always_comb begin
        operand = src;
        if (idx == 5'd0) begin
            operand = {W{1'b0}};
        end else if (wb_hits(wb_wr, wb_rd, idx)) begin
            operand = wb_data;
        end else begin
            operand = src;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: drives regfile addresses, captures 1-cycle-late data, holds under back-pressure.
// Build option OPFETCH_BYPASS_EN enables pending-bypass capture and live writeback forwarding.
module operand_fetch
    import rv_pkg::*;
#(
    parameter int XLEN   = rv_pkg::XLEN,
    parameter int CTRL_W = rv_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [4:0]        rf_rs1,
    output logic [4:0]        rf_rs2,
    input  logic [XLEN-1:0]   rf_rs1_d,
    input  logic [XLEN-1:0]   rf_rs2_d,
    input  logic              wb_wr,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rs1_d,
    output logic [XLEN-1:0]   out_rs2_d,
    output logic [4:0]        out_rd,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_imm,
    output logic [CTRL_W-1:0] out_ctrl
);

`ifdef OPFETCH_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    opfetch_state_t state_r, state_next_s;
    logic             in_ready_s, accept_s, fwd_wr_s;
    logic [4:0]       rs1_r, rs2_r;
    logic [XLEN-1:0]  held1_r, held2_r;
    logic [XLEN-1:0]  src1_s, src2_s, op1_s, op2_s;

    assign in_ready_s = !flush && ((state_r == OF_IDLE) || out_ready);
    assign accept_s   = in_valid && in_ready_s;
    assign in_ready   = in_ready_s;
    assign out_valid  = (state_r != OF_IDLE);
    assign fwd_wr_s   = wb_wr & BYPASS_EN;
    assign rf_rs1     = rstn ? in_rs1 : 5'd0;
    assign rf_rs2     = rstn ? in_rs2 : 5'd0;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= OF_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state: flush wins, a transfer with a new accept refills READ with no bubble.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = OF_IDLE;
        end else begin
            case (state_r)
                OF_IDLE: begin
                    if (accept_s) state_next_s = OF_READ;
                    else          state_next_s = OF_IDLE;
                end
                OF_READ, OF_HOLD: begin
                    if (out_ready) state_next_s = accept_s ? OF_READ : OF_IDLE;
                    else           state_next_s = OF_HOLD;
                end
                default: state_next_s = OF_IDLE;
            endcase
        end
    end

    // Capture pass-through fields and source indices on accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rs1_r    <= 5'd0;
            rs2_r    <= 5'd0;
            out_rd   <= 5'd0;
            out_pc   <= {XLEN{1'b0}};
            out_imm  <= {XLEN{1'b0}};
            out_ctrl <= {CTRL_W{1'b0}};
        end else if (accept_s) begin
            rs1_r    <= in_rs1;
            rs2_r    <= in_rs2;
            out_rd   <= in_rd;
            out_pc   <= in_pc;
            out_imm  <= in_imm;
            out_ctrl <= in_ctrl;
        end
    end

`ifdef OPFETCH_BYPASS_EN
    logic            pend1_r, pend2_r;
    logic [XLEN-1:0] pend_data1_r, pend_data2_r;

    // A write on the accept edge is invisible to the regfile read, so remember it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend1_r      <= 1'b0;
            pend2_r      <= 1'b0;
            pend_data1_r <= {XLEN{1'b0}};
            pend_data2_r <= {XLEN{1'b0}};
        end else if (accept_s) begin
            pend1_r      <= wb_hits(wb_wr, wb_rd, in_rs1);
            pend2_r      <= wb_hits(wb_wr, wb_rd, in_rs2);
            pend_data1_r <= wb_data;
            pend_data2_r <= wb_data;
        end
    end

    assign src1_s = (state_r == OF_READ) ? (pend1_r ? pend_data1_r : rf_rs1_d) : held1_r;
    assign src2_s = (state_r == OF_READ) ? (pend2_r ? pend_data2_r : rf_rs2_d) : held2_r;

    // Track the forwarded operand every stalled cycle so later writebacks stay visible.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            held1_r <= {XLEN{1'b0}};
            held2_r <= {XLEN{1'b0}};
        end else if (!flush && (state_r != OF_IDLE) && !out_ready) begin
            held1_r <= op1_s;
            held2_r <= op2_s;
        end
    end
`else
    assign src1_s = (state_r == OF_READ) ? rf_rs1_d : held1_r;
    assign src2_s = (state_r == OF_READ) ? rf_rs2_d : held2_r;

    // Freeze the regfile data once on entry to HOLD.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            held1_r <= {XLEN{1'b0}};
            held2_r <= {XLEN{1'b0}};
        end else if (!flush && (state_r == OF_READ) && !out_ready) begin
            held1_r <= op1_s;
            held2_r <= op2_s;
        end
    end
`endif

    opfetch_fwd #(.W(XLEN)) u_fwd1 (
        .idx     (rs1_r),
        .src     (src1_s),
        .wb_wr   (fwd_wr_s),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .operand (op1_s)
    );

    opfetch_fwd #(.W(XLEN)) u_fwd2 (
        .idx     (rs2_r),
        .src     (src2_s),
        .wb_wr   (fwd_wr_s),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .operand (op2_s)
    );

    assign out_rs1_d = op1_s;
    assign out_rs2_d = op2_s;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: architectural-register model, per-cycle compare, literal pins.
module tb_operand_fetch;

    localparam int XW = 32;
    localparam int CW = 16;

    logic          clk, rstn, flush, in_valid, in_ready;
    logic [4:0]    in_rs1, in_rs2, in_rd, rf_rs1, rf_rs2, wb_rd, out_rd;
    logic [XW-1:0] in_pc, in_imm, rf_rs1_d, rf_rs2_d, wb_data;
    logic [XW-1:0] out_rs1_d, out_rs2_d, out_pc, out_imm;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic          wb_wr, out_valid, out_ready;

    operand_fetch #(.XLEN(XW), .CTRL_W(CW)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_pc(in_pc), .in_imm(in_imm), .in_ctrl(in_ctrl),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_d(rf_rs1_d), .rf_rs2_d(rf_rs2_d),
        .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_d(out_rs1_d), .out_rs2_d(out_rs2_d),
        .out_rd(out_rd), .out_pc(out_pc), .out_imm(out_imm), .out_ctrl(out_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int xfer_cnt = 0;
    logic run = 1'b0;
    logic preload;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Architectural register file, also acting as the synchronous-read regfile.
    logic [XW-1:0] regs [32];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) regs[i] <= {16'hA000, 11'd0, 5'(i)};
            regs[0] <= 32'h0;
            regs[3] <= 32'h11;
            regs[4] <= 32'h22;
            regs[5] <= 32'h0;
            regs[7] <= 32'h77;
        end else begin
            rf_rs1_d <= regs[rf_rs1];
            rf_rs2_d <= regs[rf_rs2];
            if (wb_wr && wb_rd != 5'd0) regs[wb_rd] <= wb_data;
        end
    end

    // Transaction model: which instruction the stage holds, from the handshake rules.
    logic          m_valid;
    logic [4:0]    m_rs1, m_rs2, m_rd;
    logic [XW-1:0] m_pc, m_imm, m_snap1, m_snap2;
    logic [CW-1:0] m_ctrl;
    logic          exp_in_ready;
    assign exp_in_ready = !flush && (!m_valid || out_ready);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (in_valid && exp_in_ready) begin
            m_valid <= 1'b1;
            m_rs1 <= in_rs1; m_rs2 <= in_rs2; m_rd <= in_rd;
            m_pc <= in_pc; m_imm <= in_imm; m_ctrl <= in_ctrl;
            m_snap1 <= regs[in_rs1];
            m_snap2 <= regs[in_rs2];
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Operand the execute stage must see: latest register value, or the accept-time value without bypass.
    function automatic logic [XW-1:0] exp_op(input int which);
        logic [4:0]    rs;
        logic [XW-1:0] snap;
        rs   = (which == 1) ? m_rs1 : m_rs2;
        snap = (which == 1) ? m_snap1 : m_snap2;
        if (rs == 5'd0) return 32'h0;
`ifdef OPFETCH_BYPASS_EN
        if (wb_wr && wb_rd == rs) return wb_data;
        return regs[rs];
`else
        return snap;
`endif
    endfunction

    always @(negedge clk) begin
        if (run) begin
            if (!rstn) begin
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_out_rs1", out_rs1_d, 32'd0);
                chk("rst_out_pc", out_pc, 32'd0);
            end else begin
                chk("in_ready", 32'(in_ready), 32'(exp_in_ready));
                chk("out_valid", 32'(out_valid), 32'(m_valid));
                if (m_valid) begin
                    chk("out_rs1_d", out_rs1_d, exp_op(1));
                    chk("out_rs2_d", out_rs2_d, exp_op(2));
                    chk("out_rd", 32'(out_rd), 32'(m_rd));
                    chk("out_pc", out_pc, m_pc);
                    chk("out_imm", out_imm, m_imm);
                    chk("out_ctrl", 32'(out_ctrl), 32'(m_ctrl));
                end
                if (in_valid && exp_in_ready) begin
                    chk("rf_rs1", 32'(rf_rs1), 32'(in_rs1));
                    chk("rf_rs2", 32'(rf_rs2), 32'(in_rs2));
                end
                if (out_valid && out_ready && !flush) xfer_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic [XW-1:0] pc);
        in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_pc = pc;
        in_imm = pc ^ 32'h5A5A_0000;
        in_ctrl = pc[15:0] ^ 16'h00FF;
    endtask

    int start;

    initial begin
        rstn = 1'b0; preload = 1'b1; flush = 1'b0; out_ready = 1'b0;
        wb_wr = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        drive(1'b0, 5'd9, 5'd10, 5'd0, 32'h0);
        tick(); tick();
        preload = 1'b0;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_pc", out_pc, 32'd0);
        chk("reset_rf_rs1", 32'(rf_rs1), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rstn = 1'b1; run = 1'b1;
        tick();

        // Back-to-back stream at full rate.
        out_ready = 1'b1;
        drive(1'b1, 5'd3, 5'd4, 5'd1, 32'h100);
        tick();
        start = xfer_cnt;
        drive(1'b1, 5'd4, 5'd3, 5'd2, 32'h104);
        settle();
        chk("s1_op1", out_rs1_d, 32'h11);
        chk("s1_op2", out_rs2_d, 32'h22);
        chk("s1_in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 5'd3, 5'd3, 5'd3, 32'h108);
        tick();
        drive(1'b1, 5'd4, 5'd4, 5'd4, 32'h10C);
        tick();
        in_valid = 1'b0;
        tick();
        settle();
        chk("s1_xfer4", 32'(xfer_cnt - start), 32'd4);
        chk("s1_drained", 32'(out_valid), 32'd0);
        tick();

        // Writeback on the accept edge.
        drive(1'b1, 5'd5, 5'd0, 5'd6, 32'h200);
        wb_wr = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD;
        tick();
        wb_wr = 1'b0; in_valid = 1'b0;
        settle();
`ifdef OPFETCH_BYPASS_EN
        chk("s2_pend_bypass", out_rs1_d, 32'hDEAD);
`else
        chk("s2_pend_bypass", out_rs1_d, 32'h0);
`endif
        tick();

        // Stall with a writeback during HOLD.
        drive(1'b1, 5'd1, 5'd7, 5'd8, 32'h300);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        start = xfer_cnt;
        settle();
        chk("s3_ready_c1", 32'(in_ready), 32'd0);
        chk("s3_op2_c1", out_rs2_d, 32'h77);
        tick();
        wb_wr = 1'b1; wb_rd = 5'd7; wb_data = 32'hBEEF;
        settle();
        chk("s3_ready_c2", 32'(in_ready), 32'd0);
`ifdef OPFETCH_BYPASS_EN
        chk("s3_op2_c2", out_rs2_d, 32'hBEEF);
`else
        chk("s3_op2_c2", out_rs2_d, 32'h77);
`endif
        tick();
        wb_wr = 1'b0;
        settle();
`ifdef OPFETCH_BYPASS_EN
        chk("s3_op2_c3", out_rs2_d, 32'hBEEF);
`else
        chk("s3_op2_c3", out_rs2_d, 32'h77);
`endif
        tick();
        out_ready = 1'b1;
        tick();
        settle();
        chk("s3_single_xfer", 32'(xfer_cnt - start), 32'd1);
        tick();

        // x0 never forwarded.
        drive(1'b1, 5'd0, 5'd2, 5'd9, 32'h400);
        wb_wr = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        tick();
        in_valid = 1'b0;
        settle();
        chk("s4_x0", out_rs1_d, 32'h0);
        tick();
        wb_wr = 1'b0;
        tick();

        // Flush from HOLD blocks the incoming instruction.
        drive(1'b1, 5'd6, 5'd8, 5'd10, 32'h500);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, 5'd9, 5'd10, 5'd11, 32'h504);
        settle();
        chk("s5_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        settle();
        chk("s5_out_valid", 32'(out_valid), 32'd0);
        tick();
        settle();
        chk("s5_not_accepted", 32'(out_valid), 32'd0);
        tick();

        // Asynchronous reset mid-HOLD, then a clean accept.
        drive(1'b1, 5'd3, 5'd4, 5'd12, 32'h600);
        out_ready = 1'b0;
        tick();
        drive(1'b0, 5'd9, 5'd10, 5'd0, 32'h0);
        tick();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("s6_valid", 32'(out_valid), 32'd0);
        chk("s6_rs1", out_rs1_d, 32'd0);
        chk("s6_rs2", out_rs2_d, 32'd0);
        chk("s6_rd", 32'(out_rd), 32'd0);
        chk("s6_pc", out_pc, 32'd0);
        chk("s6_imm", out_imm, 32'd0);
        chk("s6_ctrl", 32'(out_ctrl), 32'd0);
        chk("s6_rf_rs1", 32'(rf_rs1), 32'd0);
        tick();
        rstn = 1'b1; out_ready = 1'b1;
        drive(1'b1, 5'd3, 5'd4, 5'd13, 32'h700);
        tick();
        in_valid = 1'b0;
        settle();
        chk("s6_after_valid", 32'(out_valid), 32'd1);
        chk("s6_after_op1", out_rs1_d, 32'h11);
        chk("s6_after_op2", out_rs2_d, 32'h22);
        tick();
        tick();

        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Register-read stage directly upstream of the execute stage; drives the read addresses of the 32x32 synchronous-read register file and captures its 1-cycle-late read data.
- Corrects stale reads with writeback forwarding, because the register file does not forward same-edge writes.
- Holds operands under downstream back-pressure with a valid/ready handshake on both sides.

Parameters:
XLEN, 32, data width of operands, pc, imm and writeback data
CTRL_W, 16, width of opaque decoded-control bundle passed through unchanged

Ports:
clk  in  1  sole clock, rising edge
rstn  in  1  asynchronous active-low reset
flush  in  1  drop in-flight instruction (branch/trap redirect)
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts instruction this cycle
in_rs1  in  5  source register 1 index
in_rs2  in  5  source register 2 index
in_rd  in  5  destination index, passed through
in_pc  in  XLEN  passed through
in_imm  in  XLEN  passed through
in_ctrl  in  CTRL_W  passed through
rf_rs1  out  5  register-file read address 1
rf_rs2  out  5  register-file read address 2
rf_rs1_d  in  XLEN  register-file read data 1, valid 1 cycle after address sampled
rf_rs2_d  in  XLEN  register-file read data 2
wb_wr  in  1  writeback strobe (same signal driving register-file write)
wb_rd  in  5  writeback index
wb_data  in  XLEN  writeback data
out_valid  out  1  operands valid to execute
out_ready  in  1  execute accepts
out_rs1_d  out  XLEN  operand 1
out_rs2_d  out  XLEN  operand 2
out_rd, out_pc, out_imm, out_ctrl  out  5/XLEN/XLEN/CTRL_W  registered pass-through

Behaviour:
- States:
  - IDLE: empty.
  - READ: register-file data arriving this cycle.
  - HOLD: operands in local registers.
- Reset (rstn=0, async):
  - state=IDLE, out_valid=0.
  - All out_* data, held operands and pending flags = 0.
  - rf_rs1/rf_rs2 = 0.
- Handshake:
  - in_ready = !flush && (state==IDLE || out_ready).
  - Accept when in_valid && in_ready.
  - out_valid = (state!=IDLE).
  - Transfer out when out_valid && out_ready.
- Read addresses: rf_rs1/rf_rs2 = in_rs1/in_rs2 combinationally, and are don't-care when not accepting.
- Accept edge:
  - Register rd/pc/imm/ctrl and rs1/rs2 indices; go to READ.
  - Pending-bypass: if wb_wr && wb_rd==rsN && rsN!=0 at that edge, set pendN and capture wb_data, because the register file returned the pre-write value.
- Operand source:
  - READ: source = pendN ? pend_dataN : rf_rsN_d.
  - HOLD: source = heldN.
- Live forwarding: out_rsN_d = (wb_wr && wb_rd==rsN && rsN!=0) ? wb_data : source. Forward-to-output latency is 0 cycles.
- rsN==0 forces out_rsN_d=0 regardless of any source.
- Transitions:
  - READ/HOLD with out_ready: go to READ if accepting a new instruction, else IDLE.
  - READ without out_ready: go to HOLD; heldN <= out_rsN_d (forwarded value).
  - HOLD without out_ready: heldN <= out_rsN_d every cycle, so later writebacks stay visible.
- Simultaneous out transfer and accept: new instruction enters READ with no bubble, giving throughput of 1 per cycle.
- flush: next state IDLE, out_valid=0 next cycle; in_ready=0 during flush; flush overrides out_ready.
- Mid-operation reset returns to IDLE immediately; no partial output.
- wb_rd==0 writes are never forwarded.

Optional Feature:
OPFETCH_BYPASS_EN
- Defined:
  - Pending-bypass capture and live forwarding as above.
  - HOLD registers track writebacks.
- Undefined:
  - out_rsN_d = READ ? rf_rsN_d : heldN (still 0 for x0).
  - No pendN state; held values frozen at entry to HOLD.
  - Upstream scoreboard guarantees no RAW hazards.

Decomposition:
- Shared package rv_pkg:
  - XLEN and REG_AW=5 constants.
  - opfetch_state_t enum {OF_IDLE, OF_READ, OF_HOLD}.
  - Control-bundle width constant.
- One natural sub-module: opfetch_fwd, a forwarding mux per operand (index, source, wb_wr, wb_rd, wb_data -> operand, x0 zeroing), instantiated twice.

Test Plan:
- Reset, then accept rs1=3, rs2=4 with regfile x3=0x11, x4=0x22 and out_ready=1 -> out_valid next cycle, out_rs1_d=0x11, out_rs2_d=0x22, in_ready stays 1; 4 back-to-back instructions give 4 outputs in 4 cycles.
- Accept rs1=5 on the same edge as wb_wr, wb_rd=5, wb_data=0xDEAD (regfile returns old 0x0) -> out_rs1_d=0xDEAD.
- Stall out_ready=0 for 3 cycles after accept rs2=7; writeback x7=0xBEEF in stall cycle 2 -> out_rs2_d=0xBEEF from that cycle on; in_ready=0 throughout; single transfer on release.
- rs1=0 with wb_wr, wb_rd=0, wb_data=0xFFFF_FFFF -> out_rs1_d=0.
- flush asserted while in HOLD with in_valid=1 -> out_valid=0 next cycle, in_ready=0 during flush, incoming instruction not accepted.
- rstn low mid-HOLD -> out_valid=0 and all outputs 0 asynchronously; first accept after release behaves as in scenario 1.
